// File: rtl/regfile_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_arbiter
//
// Arbitrates two requesters (A and B) onto a single-port register file.
// At most one access is performed per cycle. The grant is combinational in the
// request cycle, and the register-file controls are routed from the grantee.
// A requester that asserts lock while granted keeps ownership for as long as it
// holds req. Read data is captured one cycle after the grant and is shared by
// both requesters. rvalid_a/rvalid_b indicate which requester owns it.
//
// Configuration macro:
//   RF_ARB_FIXED_PRI_EN  defined   : A always wins a tie in IDLE.
//                        undefined : round robin. The requester that was not
//                                    granted most recently wins a tie.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_a/b, we_a/b          request, 1 = write / 0 = read
//   lock_a/b                 keep ownership after the current grant
//   addr_a/b  [AW:0]         target register
//   wdata_a/b [DW:0]         write data
//   gnt_a/b                  access performed this cycle (combinational)
//   rvalid_a/b               rdata valid for A / B (registered)
//   rdata     [DW:0]         registered read data
//   rf_we, rf_waddr, rf_raddr, rf_wdata   register-file controls
//   rf_rdata  [DW:0]         combinational read data from the register file
// -----------------------------------------------------------------------------
module regfile_arbiter #(
    parameter int AW = 2,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic          lock_a,
    input  logic          lock_b,
    input  logic [AW:0]   addr_a,
    input  logic [AW:0]   addr_b,
    input  logic [DW:0]   wdata_a,
    input  logic [DW:0]   wdata_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          rvalid_a,
    output logic          rvalid_b,
    output logic [DW:0]   rdata,
    output logic          rf_we,
    output logic [AW:0]   rf_waddr,
    output logic [AW:0]   rf_raddr,
    output logic [DW:0]   rf_wdata,
    input  logic [DW:0]   rf_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          gnt_a_s;
    logic          gnt_b_s;
    logic [AW:0]   addr_hold_q;
    logic [AW:0]   addr_hold_d;
    logic [DW:0]   wdata_hold_q;
    logic [DW:0]   wdata_hold_d;
    logic [AW:0]   addr_sel_s;
    logic [DW:0]   wdata_sel_s;
    logic          rvalid_a_q;
    logic          rvalid_b_q;
    logic [DW:0]   rdata_q;
    logic [DW:0]   rdata_d;

`ifndef RF_ARB_FIXED_PRI_EN
    // last_b_q = 1 when B was the most recent grantee.
    logic          last_b_q;
    logic          last_b_d;
`endif

    // Arbitration and next-state logic.
    always_comb begin
        gnt_a_s = 1'b0;
        gnt_b_s = 1'b0;
        state_d = IDLE;
`ifndef RF_ARB_FIXED_PRI_EN
        last_b_d = last_b_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
`ifdef RF_ARB_FIXED_PRI_EN
                    gnt_a_s = 1'b1;
`else
                    if (last_b_q) begin
                        gnt_a_s = 1'b1;
                    end else begin
                        gnt_b_s = 1'b1;
                    end
`endif
                end else begin
                    gnt_a_s = req_a;
                    gnt_b_s = req_b;
                end
            end
            OWN_A: begin
                gnt_a_s = req_a;
            end
            OWN_B: begin
                gnt_b_s = req_b;
            end
            default: begin
                // Unreachable encoding: grant nothing and fall back to IDLE.
                gnt_a_s = 1'b0;
                gnt_b_s = 1'b0;
            end
        endcase

        // No access may be granted while reset is asserted.
        if (rst) begin
            gnt_a_s = 1'b0;
            gnt_b_s = 1'b0;
        end else begin
            gnt_a_s = gnt_a_s;
            gnt_b_s = gnt_b_s;
        end

        // Without a grant, ownership is released. This covers dropping req in OWN_x.
        if (gnt_a_s) begin
            state_d = lock_a ? OWN_A : IDLE;
`ifndef RF_ARB_FIXED_PRI_EN
            last_b_d = 1'b0;
`endif
        end else if (gnt_b_s) begin
            state_d = lock_b ? OWN_B : IDLE;
`ifndef RF_ARB_FIXED_PRI_EN
            last_b_d = 1'b1;
`endif
        end else begin
            state_d = IDLE;
        end
    end

    // Register-file routing. Address and data hold their last value with no grant.
    always_comb begin
        addr_sel_s   = addr_hold_q;
        wdata_sel_s  = wdata_hold_q;
        addr_hold_d  = addr_hold_q;
        wdata_hold_d = wdata_hold_q;
        rdata_d      = rdata_q;
        if (gnt_a_s) begin
            addr_sel_s  = addr_a;
            wdata_sel_s = wdata_a;
        end else if (gnt_b_s) begin
            addr_sel_s  = addr_b;
            wdata_sel_s = wdata_b;
        end else begin
            addr_sel_s  = addr_hold_q;
            wdata_sel_s = wdata_hold_q;
        end
        addr_hold_d  = addr_sel_s;
        wdata_hold_d = wdata_sel_s;
        if ((gnt_a_s && !we_a) || (gnt_b_s && !we_b)) begin
            rdata_d = rf_rdata;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State, round-robin pointer, held routing, and read-return registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
`ifndef RF_ARB_FIXED_PRI_EN
            last_b_q     <= 1'b1;
`endif
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
            rvalid_a_q   <= 1'b0;
            rvalid_b_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
`ifndef RF_ARB_FIXED_PRI_EN
            last_b_q     <= last_b_d;
`endif
            addr_hold_q  <= addr_hold_d;
            wdata_hold_q <= wdata_hold_d;
            rvalid_a_q   <= gnt_a_s & ~we_a;
            rvalid_b_q   <= gnt_b_s & ~we_b;
            rdata_q      <= rdata_d;
        end
    end

    assign gnt_a    = gnt_a_s;
    assign gnt_b    = gnt_b_s;
    assign rf_we    = (gnt_a_s & we_a) | (gnt_b_s & we_b);
    assign rf_waddr = addr_sel_s;
    assign rf_raddr = addr_sel_s;
    assign rf_wdata = wdata_sel_s;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_arbiter. It contains a register-file model driven by
// the DUT, a behavioural reference model checked on every negative clock edge,
// directed scenarios with literal expectations, and a randomized phase.
// -----------------------------------------------------------------------------
module tb_regfile_arbiter;

    localparam int AW    = 2;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << (AW + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          req_a, req_b, we_a, we_b, lock_a, lock_b;
    logic [AW:0]   addr_a, addr_b;
    logic [DW:0]   wdata_a, wdata_b;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DW:0]   rdata;
    logic          rf_we;
    logic [AW:0]   rf_waddr, rf_raddr;
    logic [DW:0]   rf_wdata;
    logic [DW:0]   rf_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .lock_a(lock_a), .lock_b(lock_b),
        .addr_a(addr_a), .addr_b(addr_b),
        .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .rvalid_a(rvalid_a), .rvalid_b(rvalid_b), .rdata(rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_raddr(rf_raddr),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    always #5 clk = ~clk;

    // Register file driven by the DUT. It is cleared on reset.
    logic [DW:0] rf_mem [DEPTH];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) rf_mem[i] <= '0;
        end else if (rf_we) begin
            rf_mem[rf_waddr] <= rf_wdata;
        end
    end
    assign rf_rdata = rf_mem[rf_raddr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. owner: 0 none, 1 A, 2 B. last: 1 A, 2 B.
    int          m_owner;
    int          m_last;
    logic [AW:0] m_hold_addr;
    logic [DW:0] m_hold_wdata;
    logic        m_rva, m_rvb;
    logic [DW:0] m_rdata;
    logic [DW:0] ref_mem [DEPTH];

    function automatic void model_grant(output logic ga, output logic gb);
        ga = 1'b0;
        gb = 1'b0;
        if (m_owner == 1) begin
            ga = req_a;
        end else if (m_owner == 2) begin
            gb = req_b;
        end else if (req_a && req_b) begin
`ifdef RF_ARB_FIXED_PRI_EN
            ga = 1'b1;
`else
            if (m_last == 2) ga = 1'b1;
            else gb = 1'b1;
`endif
        end else begin
            ga = req_a;
            gb = req_b;
        end
    endfunction

    // Update the model at each active clock edge, or immediately on reset.
    always @(posedge clk or posedge rst) begin
        logic ga, gb;
        if (rst) begin
            m_owner = 0; m_last = 2;
            m_hold_addr = '0; m_hold_wdata = '0;
            m_rva = 1'b0; m_rvb = 1'b0; m_rdata = '0;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else begin
            model_grant(ga, gb);
            m_rva = ga && !we_a;
            m_rvb = gb && !we_b;
            if (ga) begin
                m_hold_addr = addr_a; m_hold_wdata = wdata_a;
                m_last = 1; m_owner = lock_a ? 1 : 0;
                if (we_a) ref_mem[addr_a] = wdata_a;
                else m_rdata = ref_mem[addr_a];
            end else if (gb) begin
                m_hold_addr = addr_b; m_hold_wdata = wdata_b;
                m_last = 2; m_owner = lock_b ? 2 : 0;
                if (we_b) ref_mem[addr_b] = wdata_b;
                else m_rdata = ref_mem[addr_b];
            end else begin
                m_owner = 0;
            end
        end
    end

    // Compare the DUT outputs with the model on every negative clock edge.
    always @(negedge clk) begin
        logic ga, gb, ewe;
        logic [AW:0] ea;
        logic [DW:0] ed;
        if (rst) begin
            ga = 1'b0; gb = 1'b0;
        end else begin
            model_grant(ga, gb);
        end
        ewe = (ga && we_a) || (gb && we_b);
        ea  = ga ? addr_a  : (gb ? addr_b  : m_hold_addr);
        ed  = ga ? wdata_a : (gb ? wdata_b : m_hold_wdata);
        chk("m_gnt_a", gnt_a, ga);
        chk("m_gnt_b", gnt_b, gb);
        chk("m_rf_we", rf_we, ewe);
        chk("m_rf_waddr", rf_waddr, ea);
        chk("m_rf_raddr", rf_raddr, ea);
        if (ewe) chk("m_rf_wdata", rf_wdata, ed);
        chk("m_rvalid_a", rvalid_a, m_rva);
        chk("m_rvalid_b", rvalid_b, m_rvb);
        chk("m_rdata", rdata, m_rdata);
    end

    task automatic drv(input logic ra, input logic wa, input logic la,
                       input logic [AW:0] aa, input logic [DW:0] da,
                       input logic rb, input logic wb, input logic lb,
                       input logic [AW:0] ab, input logic [DW:0] db);
        req_a = ra; we_a = wa; lock_a = la; addr_a = aa; wdata_a = da;
        req_b = rb; we_b = wb; lock_b = lb; addr_b = ab; wdata_b = db;
        @(negedge clk);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 1'b0, 3'd0, 17'd0, 1'b0, 1'b0, 1'b0, 3'd0, 17'd0);
    endtask

    // Assert reset (starting just after a posedge), check the reset state, and release.
    task automatic do_reset();
        rst = 1'b1;
        idle();
        chk("rst_gnt_a", gnt_a, 32'd0);
        chk("rst_rvalid_a", rvalid_a, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rf_waddr", rf_waddr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1;
        req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        lock_a = 1'b0; lock_b = 1'b0;
        addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
        #1;
        do_reset();

        // A writes addr 2 = 0x1234, then reads it back.
        drv(1'b1, 1'b1, 1'b0, 3'd2, 17'h1234, 1'b0, 1'b0, 1'b0, 3'd0, 17'd0);
        chk("wr_gnt_a", gnt_a, 32'd1);
        chk("wr_rf_we", rf_we, 32'd1);
        next_cyc();
        drv(1'b1, 1'b0, 1'b0, 3'd2, 17'd0, 1'b0, 1'b0, 1'b0, 3'd0, 17'd0);
        chk("rd_gnt_a", gnt_a, 32'd1);
        chk("rd_rvalid_early", rvalid_a, 32'd0);
        next_cyc();
        idle();
        chk("rd_rvalid_a", rvalid_a, 32'd1);
        chk("rd_rdata", rdata, 32'h1234);
        chk("idle_hold_addr", rf_raddr, 32'd2);
        next_cyc();
        idle();
        chk("rvalid_one_cycle", rvalid_a, 32'd0);
        chk("rdata_hold", rdata, 32'h1234);
        next_cyc();

        // Four unlocked tie cycles.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 1'b0, 1'b0, 3'(i), 17'd0, 1'b1, 1'b0, 1'b0, 3'(i), 17'd0);
`ifdef RF_ARB_FIXED_PRI_EN
            chk("tie_gnt_a", gnt_a, 32'd1);
`else
            chk("tie_gnt_a", gnt_a, (i % 2 == 0) ? 32'd1 : 32'd0);
`endif
            next_cyc();
        end

        // A locks for three requests while B waits.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 1'b0, 1'b1, 3'd3, 17'd0, 1'b1, 1'b0, 1'b0, 3'd5, 17'd0);
            chk("lock_gnt_a", gnt_a, 32'd1);
            chk("lock_gnt_b", gnt_b, 32'd0);
            next_cyc();
        end
        drv(1'b0, 1'b0, 1'b0, 3'd3, 17'd0, 1'b1, 1'b0, 1'b0, 3'd5, 17'd0);
        chk("release_gnt_b", gnt_b, 32'd0);
        next_cyc();
        drv(1'b0, 1'b0, 1'b0, 3'd3, 17'd0, 1'b1, 1'b0, 1'b0, 3'd5, 17'd0);
        chk("after_gnt_b", gnt_b, 32'd1);
        next_cyc();

        // Both requesters write addr 1. Then B reads it.
        do_reset();
        drv(1'b1, 1'b1, 1'b0, 3'd1, 17'h00AA, 1'b1, 1'b1, 1'b0, 3'd1, 17'h00BB);
        chk("dual_wr_gnt_a", gnt_a, 32'd1);
        next_cyc();
        drv(1'b0, 1'b0, 1'b0, 3'd1, 17'd0, 1'b1, 1'b1, 1'b0, 3'd1, 17'h00BB);
        chk("dual_wr_gnt_b", gnt_b, 32'd1);
        next_cyc();
        drv(1'b0, 1'b0, 1'b0, 3'd1, 17'd0, 1'b1, 1'b0, 1'b0, 3'd1, 17'd0);
        chk("b_rd_gnt_b", gnt_b, 32'd1);
        next_cyc();
        idle();
        chk("b_rvalid_b", rvalid_b, 32'd1);
        chk("b_rdata", rdata, 32'h00BB);
        next_cyc();

        // Reset in the cycle after a read grant. Then read every register.
        drv(1'b1, 1'b0, 1'b0, 3'd1, 17'd0, 1'b0, 1'b0, 1'b0, 3'd0, 17'd0);
        chk("pre_rst_gnt_a", gnt_a, 32'd1);
        next_cyc();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drv(1'b1, 1'b0, 1'b0, 3'(i), 17'd0, 1'b0, 1'b0, 1'b0, 3'd0, 17'd0);
            next_cyc();
        end
        idle();
        chk("post_rst_rvalid", rvalid_a, 32'd1);
        chk("post_rst_rdata", rdata, 32'd0);
        next_cyc();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
            end else begin
                r = $urandom;
                req_a  = (r[1:0] != 2'd0);
                req_b  = (r[3:2] != 2'd0);
                we_a   = r[4];
                we_b   = r[5];
                lock_a = (r[7:6] == 2'd0);
                lock_b = (r[9:8] == 2'd0);
                addr_a = r[12:10];
                addr_b = r[15:13];
                r = $urandom;
                wdata_a = r[16:0];
                r = $urandom;
                wdata_b = r[16:0];
                next_cyc();
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 The parameter list SHALL be: AW, default 2, register-file address parameter (address ports are AW+1 bits).
REQ-002 The parameter list SHALL also include DW, default 16, register-file data parameter (data ports are DW+1 bits).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; ports are listed clock and reset first.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous reset, active high.
REQ-006 req_a, req_b  in  1  access request from requester A / B.
REQ-007 we_a, we_b  in  1  1 = write, 0 = read.
REQ-008 lock_a, lock_b  in  1  keep ownership after the current grant.
REQ-009 addr_a, addr_b  in  AW+1  target register.
REQ-010 wdata_a, wdata_b  in  DW+1  write data.
REQ-011 gnt_a, gnt_b  out  1  access performed this cycle.
REQ-012 rvalid_a, rvalid_b  out  1  rdata valid for A / B.
REQ-013 rdata  out  DW+1  registered read data, shared by both requesters.
REQ-014 rf_we  out  1  drives the register-file write enable.
REQ-015 rf_waddr, rf_raddr  out  AW+1  drive the register-file write and read addresses.
REQ-016 rf_wdata  out  DW+1  drives the register-file write data.
REQ-017 rf_rdata  in  DW+1  combinational read data returned by the register file.

Function
REQ-018 The block SHALL perform at most one access per cycle: gnt_a and gnt_b are never both 1.
REQ-019 Grant timing SHALL be combinational in the same cycle as the request, with the register-file signals routed from the granted requester.
- rf_we = we_x & gnt_x.
- rf_waddr = rf_raddr = addr_x.
- rf_wdata = wdata_x.
REQ-020 With no grant, rf_we SHALL be 0 and the address/data outputs SHALL hold their previous values.
REQ-021 A write SHALL commit at the clock edge ending the grant cycle.
REQ-022 A read SHALL load rf_rdata into rdata at the grant-cycle edge, and rvalid_x SHALL be 1 for exactly the following cycle (latency 1).
REQ-023 rdata SHALL hold its value until the next read grant.
REQ-024 The FSM SHALL have three states: IDLE, OWN_A, OWN_B.
- IDLE: arbitrate between req_a and req_b.
- OWN_A: only A may be granted; req_b waits.
- OWN_B: mirror of OWN_A.
REQ-025 FSM transitions SHALL be as follows:
- A is granted with lock_a=1 -> OWN_A.
- A is granted with lock_a=0 -> IDLE.
- In OWN_A with req_a=0 -> IDLE.
- OWN_B is symmetric.
REQ-026 A round-robin pointer `last` SHALL record the most recent grantee. On a simultaneous request in IDLE, the requester that is not `last` wins.
REQ-027 A single requester SHALL be granted back-to-back every cycle while it holds req.
REQ-028 A same-cycle write followed by a read of the same address SHALL return the newly written data.

Reset
REQ-029 While rst=1, asynchronously:
- state = IDLE, last = B (so A wins the first tie);
- gnt_a = gnt_b = 0, rvalid_a = rvalid_b = 0;
- rdata = 0, rf_we = 0, rf_waddr = rf_raddr = 0, rf_wdata = 0.
REQ-030 A reset asserted mid-operation SHALL abort any pending read (no rvalid is issued), and no write SHALL occur at the edge where rst=1.

Configuration
REQ-031 The macro RF_ARB_FIXED_PRI_EN SHALL select the arbitration policy.
- Defined: A always wins ties in IDLE, and `last` is unused.
- Undefined: round-robin as in REQ-026.
- Locking behaviour is the same in both builds.

Verification
REQ-032 A bench SHALL cover at least these scenarios:
- Reset, then A writes addr 2 = 0x1234, then A reads addr 2 -> gnt_a in each request cycle, rvalid_a one cycle after the read grant, rdata = 0x1234.
- req_a and req_b high for 4 cycles, unlocked -> grants A,B,A,B (round robin); with RF_ARB_FIXED_PRI_EN -> A,A,A,A.
- A holds lock_a=1 for 3 requests while req_b is high -> gnt_a for 3 cycles, gnt_b only after req_a drops.
- A and B simultaneously write addr 1 with 0x00AA and 0x00BB, then B reads addr 1 -> the value reflects the grant order and matches the model.
- rst asserted in the cycle after a read grant -> rvalid low and rdata = 0; after reset, all registers read 0.
